eep_arb: RTL and testbench
==========================

# eep_arb

EEPROM access sequencer and arbiter for `cbc_dig`. It sits between the 4×14-bit coefficient EEPROM (`eep`) and three requesters:
- an internal boot loader that copies xset/P/I/D into the datapath after reset;
- the command-mode controller (read/write via config UART);
- the datapath (on-demand coefficient re-read).

It owns all EEPROM pin timing, including the 3 ms charge-pump window for writes.

## Interface
- `CP_CYCLES`, default 1500000, clock cycles `chrg_pmp_en` is held per write (3 ms at 500 MHz).
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmd_req`  in  1  command request, level, held until `cmd_done`.
- `cmd_wr`  in  1  1 = write, 0 = read; stable while `cmd_req`.
- `cmd_addr`  in  2  EEPROM address; stable while `cmd_req`.
- `cmd_wdata`  in  14  write data; stable while `cmd_req`.
- `cmd_done`  out  1  one-cycle completion pulse.
- `cmd_rdata`  out  14  read data; valid with `cmd_done`, held until the next capture.
- `dp_req`  in  1  datapath read request, level, held until `dp_vld`.
- `dp_addr`  in  2  datapath read address.
- `dp_vld`  out  1  one-cycle pulse; `dp_rdata` valid.
- `dp_rdata`  out  14  datapath read data.
- `coef_ld`  out  4  one-hot boot load strobe; bit n = address n.
- `coef_data`  out  14  boot load data; valid with `coef_ld`.
- `boot_done`  out  1  high once all four boot loads are complete.
- `eep_addr`  out  2  EEPROM address.
- `eep_cs_n`  out  1  EEPROM chip select, active low.
- `eep_r_w_n`  out  1  1 = read, 0 = write.
- `chrg_pmp_en`  out  1  charge-pump enable during a write.
- `dst`  out  14  EEPROM write data.
- `eep_rd_data`  in  14  EEPROM read data; combinational from `eep_addr` while `eep_cs_n` = 0.

## Operation
- Reset values:
  - `eep_cs_n` = 1, `eep_r_w_n` = 1, `chrg_pmp_en` = 0.
  - `eep_addr` = 0, `dst` = 0.
  - `cmd_done` = 0, `dp_vld` = 0, `coef_ld` = 0, `boot_done` = 0.
  - `cmd_rdata`, `dp_rdata`, `coef_data` = 0.
- States:
  - BOOT_CS → BOOT_GAP: loops for n = 0..3.
  - IDLE.
  - RD_CS → RD_GAP.
  - WR_PMP → WR_GAP.
- Boot sequence:
  - Reads addresses 0, 1, 2, 3 in order.
  - Each read captures `eep_rd_data` and pulses `coef_ld[n]`.
  - After n = 3 the block enters IDLE and sets `boot_done`, which stays high until reset.
- Request handling:
  - `cmd_req` and `dp_req` are ignored until `boot_done` = 1.
  - Arbitration is sampled in IDLE only, with fixed priority cmd > dp.
  - The losing request stays pending and is served at the next IDLE.
- Read access:
  - RD_CS: `eep_cs_n` = 0, `eep_r_w_n` = 1, address driven.
  - The edge ending RD_CS captures `eep_rd_data`.
  - RD_GAP: `eep_cs_n` = 1 and the requester's done/vld pulses.
- Write access (cmd only):
  - WR_PMP: `eep_cs_n` = 0, `eep_r_w_n` = 0, `chrg_pmp_en` = 1.
  - `eep_addr` and `dst` hold the latched `cmd_addr` and `cmd_wdata` for exactly `CP_CYCLES` cycles.
  - WR_GAP: all EEPROM strobes are deasserted and `cmd_done` pulses.
  - `cmd_rdata` is unchanged by a write.
- Gap rule: `eep_cs_n` is high for at least one cycle between any two accesses (the *_GAP states).
- Request latching: address and data are latched on grant, so later changes on the request inputs do not affect an access in flight.
- Reset mid-operation:
  - All outputs return to their reset values immediately (asynchronous).
  - A write in progress is aborted and `chrg_pmp_en` drops the same instant.
  - The boot sequence restarts from address 0 on release.

## Timing
- Boot: with cycle 0 as the first posedge after `rst_n` rises:
  - `eep_cs_n` is low in cycle 2n+1 with `eep_addr` = n.
  - `coef_ld[n]` is high in cycle 2n+2.
  - `boot_done` = 1 from cycle 9.
- Read: `cmd_req` or `dp_req` sampled high in IDLE at edge k:
  - `eep_cs_n` low in cycle k+1.
  - done/vld in cycle k+2.
  - IDLE again at k+3.
- Write: `chrg_pmp_en` is high in cycles k+1 .. k+`CP_CYCLES`, and `cmd_done` is high in cycle k+`CP_CYCLES`+1.
- Back-to-back:
  - A request still high in the done cycle is a protocol error; requesters must drop it on done.
  - A new request may be raised the cycle after done and is sampled at the next IDLE edge.

## Structure
- Shared package `cbc_pkg` holds:
  - the `eep_arb_state_t` enum;
  - address constants `XSET_ADDR` = 0, `P_ADDR` = 1, `I_ADDR` = 2, `D_ADDR` = 3;
  - the `CP_CYCLES` default.
- One sub-module `cp_timer`:
  - loadable down-counter, 21 bits wide;
  - inputs `start`; outputs `expired`;
  - drives the WR_PMP exit.
- Everything else is flat in `eep_arb`.

## Test plan
- Boot: EEPROM pre-loaded with {0x1234, 0x0ABC, 0x0101, 0x3FFF}:
  - `coef_ld` pulses 0001, 0010, 0100, 1000 in cycles 2, 4, 6, 8 with matching `coef_data`;
  - `boot_done` rises in cycle 9.
- Command read: `cmd_req` with addr 2 →
  - `eep_cs_n` low for exactly 1 cycle;
  - `cmd_done` with `cmd_rdata` = 0x0101 two cycles after the sampling edge.
- Command write: addr 1, data 0x2AAA, `CP_CYCLES` = 20 →
  - `chrg_pmp_en` high for exactly 20 cycles with `dst` = 0x2AAA and `eep_r_w_n` = 0;
  - `cmd_done` follows;
  - a subsequent read of addr 1 returns 0x2AAA.
- Collision: `cmd_req` (read addr 0) and `dp_req` (addr 3) raised on the same cycle →
  - cmd is served first;
  - `dp_vld` with `dp_rdata` = 0x3FFF follows, with ≥1 cycle of `eep_cs_n` high between the two accesses.
- Reset mid-write: `rst_n` low 10 cycles into a 20-cycle write →
  - `chrg_pmp_en` and `cmd_done` stay 0;
  - the old EEPROM value is retained;
  - the boot sequence reruns from address 0.
- Pre-boot request: `cmd_req` raised in cycle 1 → no access is issued until after `boot_done`, then it is served normally.

Source files
------------

// File: rtl/cbc_pkg.sv
// rtl/cbc_pkg.sv - shared types and constants for the cbc_dig EEPROM path
package cbc_pkg;

  localparam int unsigned CP_CYCLES_DEFAULT = 1500000;
  localparam int          CP_W              = 21;

  localparam logic [1:0] XSET_ADDR = 2'd0;
  localparam logic [1:0] P_ADDR    = 2'd1;
  localparam logic [1:0] I_ADDR    = 2'd2;
  localparam logic [1:0] D_ADDR    = 2'd3;

  typedef enum logic [2:0] {
    ST_BOOT_CS,
    ST_BOOT_GAP,
    ST_IDLE,
    ST_RD_CS,
    ST_RD_GAP,
    ST_WR_PMP,
    ST_WR_GAP
  } eep_arb_state_t;

endpackage

// File: rtl/cp_timer.sv
// rtl/cp_timer.sv - charge-pump window down-counter; expired marks the last pump cycle
module cp_timer
  import cbc_pkg::*;
#(
  parameter int unsigned CP_CYCLES = CP_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic expired
);

  localparam logic [CP_W-1:0] LOAD_VAL = CP_W'(CP_CYCLES - 1);

  logic [CP_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/eep_arb.sv
// rtl/eep_arb.sv - EEPROM boot loader, cmd/dp arbiter and pin sequencer
module eep_arb
  import cbc_pkg::*;
#(
  parameter int unsigned CP_CYCLES = CP_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_req,
  input  logic        cmd_wr,
  input  logic [1:0]  cmd_addr,
  input  logic [13:0] cmd_wdata,
  output logic        cmd_done,
  output logic [13:0] cmd_rdata,
  input  logic        dp_req,
  input  logic [1:0]  dp_addr,
  output logic        dp_vld,
  output logic [13:0] dp_rdata,
  output logic [3:0]  coef_ld,
  output logic [13:0] coef_data,
  output logic        boot_done,
  output logic [1:0]  eep_addr,
  output logic        eep_cs_n,
  output logic        eep_r_w_n,
  output logic        chrg_pmp_en,
  output logic [13:0] dst,
  input  logic [13:0] eep_rd_data
);

  eep_arb_state_t state_q, state_d;
  logic [1:0]  eep_addr_q, eep_addr_d;
  logic [13:0] dst_q, dst_d;
  logic        own_cmd_q, own_cmd_d;
  logic        boot_last_q, boot_last_d;
  logic        boot_done_q, boot_done_d;
  logic        cmd_done_q, cmd_done_d;
  logic        dp_vld_q, dp_vld_d;
  logic [3:0]  coef_ld_q, coef_ld_d;
  logic [13:0] coef_data_q, coef_data_d;
  logic [13:0] cmd_rdata_q, cmd_rdata_d;
  logic [13:0] dp_rdata_q, dp_rdata_d;
  logic        tmr_start;
  logic        tmr_expired;

  cp_timer #(.CP_CYCLES(CP_CYCLES)) u_cp_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (tmr_start),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    eep_addr_d  = eep_addr_q;
    dst_d       = dst_q;
    own_cmd_d   = own_cmd_q;
    boot_last_d = boot_last_q;
    boot_done_d = boot_done_q;
    cmd_done_d  = 1'b0;
    dp_vld_d    = 1'b0;
    coef_ld_d   = 4'b0000;
    coef_data_d = coef_data_q;
    cmd_rdata_d = cmd_rdata_q;
    dp_rdata_d  = dp_rdata_q;
    tmr_start   = 1'b0;
    unique case (state_q)
      // Reset lands here with boot_last clear, so the first edge starts the read of address 0
      ST_BOOT_GAP: begin
        if (boot_last_q) begin
          state_d     = ST_IDLE;
          boot_done_d = 1'b1;
        end else begin
          state_d = ST_BOOT_CS;
        end
      end
      ST_BOOT_CS: begin
        state_d     = ST_BOOT_GAP;
        coef_ld_d   = 4'b0001 << eep_addr_q;
        coef_data_d = eep_rd_data;
        boot_last_d = (eep_addr_q == D_ADDR);
        eep_addr_d  = eep_addr_q + 2'd1;
      end
      ST_IDLE: begin
        if (cmd_req) begin
          own_cmd_d  = 1'b1;
          eep_addr_d = cmd_addr;
          if (cmd_wr) begin
            dst_d     = cmd_wdata;
            tmr_start = 1'b1;
            state_d   = ST_WR_PMP;
          end else begin
            state_d = ST_RD_CS;
          end
        end else if (dp_req) begin
          own_cmd_d  = 1'b0;
          eep_addr_d = dp_addr;
          state_d    = ST_RD_CS;
        end
      end
      ST_RD_CS: begin
        state_d = ST_RD_GAP;
        if (own_cmd_q) begin
          cmd_done_d  = 1'b1;
          cmd_rdata_d = eep_rd_data;
        end else begin
          dp_vld_d   = 1'b1;
          dp_rdata_d = eep_rd_data;
        end
      end
      ST_RD_GAP: state_d = ST_IDLE;
      ST_WR_PMP: begin
        if (tmr_expired) begin
          state_d    = ST_WR_GAP;
          cmd_done_d = 1'b1;
        end
      end
      ST_WR_GAP: state_d = ST_IDLE;
      default:   state_d = ST_BOOT_GAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT_GAP;
      eep_addr_q  <= XSET_ADDR;
      dst_q       <= '0;
      own_cmd_q   <= 1'b0;
      boot_last_q <= 1'b0;
      boot_done_q <= 1'b0;
      cmd_done_q  <= 1'b0;
      dp_vld_q    <= 1'b0;
      coef_ld_q   <= '0;
      coef_data_q <= '0;
      cmd_rdata_q <= '0;
      dp_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      eep_addr_q  <= eep_addr_d;
      dst_q       <= dst_d;
      own_cmd_q   <= own_cmd_d;
      boot_last_q <= boot_last_d;
      boot_done_q <= boot_done_d;
      cmd_done_q  <= cmd_done_d;
      dp_vld_q    <= dp_vld_d;
      coef_ld_q   <= coef_ld_d;
      coef_data_q <= coef_data_d;
      cmd_rdata_q <= cmd_rdata_d;
      dp_rdata_q  <= dp_rdata_d;
    end
  end

  // Strobes decode straight from the state so an async reset drops the pump at once
  assign eep_cs_n    = !(state_q inside {ST_BOOT_CS, ST_RD_CS, ST_WR_PMP});
  assign eep_r_w_n   = (state_q != ST_WR_PMP);
  assign chrg_pmp_en = (state_q == ST_WR_PMP);
  assign eep_addr    = eep_addr_q;
  assign dst         = dst_q;
  assign cmd_done    = cmd_done_q;
  assign cmd_rdata   = cmd_rdata_q;
  assign dp_vld      = dp_vld_q;
  assign dp_rdata    = dp_rdata_q;
  assign coef_ld     = coef_ld_q;
  assign coef_data   = coef_data_q;
  assign boot_done   = boot_done_q;

endmodule

// File: tb/tb_eep_arb.sv
// tb/tb_eep_arb.sv - self-checking bench for eep_arb
module tb_eep_arb;

  localparam int CP = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_req = 1'b0, cmd_wr = 1'b0;
  logic [1:0]  cmd_addr = '0;
  logic [13:0] cmd_wdata = '0;
  logic        cmd_done;
  logic [13:0] cmd_rdata;
  logic        dp_req = 1'b0;
  logic [1:0]  dp_addr = '0;
  logic        dp_vld;
  logic [13:0] dp_rdata;
  logic [3:0]  coef_ld;
  logic [13:0] coef_data;
  logic        boot_done;
  logic [1:0]  eep_addr;
  logic        eep_cs_n, eep_r_w_n, chrg_pmp_en;
  logic [13:0] dst;
  logic [13:0] eep_rd_data;

  always #5 clk = ~clk;

  eep_arb #(.CP_CYCLES(CP)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_done(cmd_done), .cmd_rdata(cmd_rdata),
    .dp_req(dp_req), .dp_addr(dp_addr), .dp_vld(dp_vld), .dp_rdata(dp_rdata),
    .coef_ld(coef_ld), .coef_data(coef_data), .boot_done(boot_done),
    .eep_addr(eep_addr), .eep_cs_n(eep_cs_n), .eep_r_w_n(eep_r_w_n),
    .chrg_pmp_en(chrg_pmp_en), .dst(dst), .eep_rd_data(eep_rd_data)
  );

  // EEPROM device: a write lands only after the pump has been held a full CP cycles
  logic [13:0] eep_mem [4] = '{14'h1234, 14'h0ABC, 14'h0101, 14'h3FFF};
  int pmp_run = 0;
  assign eep_rd_data = eep_cs_n ? 14'h0000 : eep_mem[eep_addr];
  always @(posedge clk) begin
    if (chrg_pmp_en && !eep_cs_n && !eep_r_w_n) begin
      pmp_run = pmp_run + 1;
      if (pmp_run == CP) eep_mem[eep_addr] = dst;
    end else begin
      pmp_run = 0;
    end
  end

  int tests = 0;
  int fails = 0;
  logic [13:0] ref_mem [4] = '{14'h1234, 14'h0ABC, 14'h0101, 14'h3FFF};
  logic [13:0] ref_cmd_rdata = '0;

  typedef struct {
    int         cyc;
    logic       cs_n;
    logic [1:0] addr;
    logic [3:0] ld;
    int         idx;
    logic       bd;
  } boot_vec_t;
  boot_vec_t bv [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_boot(input bit pre_req);
    int dj;
    rst_n = 1'b0;
    #1;
    ref_cmd_rdata = '0;
    check("rst_ctrl", {eep_cs_n, eep_r_w_n, chrg_pmp_en, eep_addr, cmd_done, dp_vld, coef_ld, boot_done},
          {1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0});
    check("rst_data", {cmd_rdata, dp_rdata, coef_data, dst}, 56'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("boot_cs_c%0d", bv[i].cyc), eep_cs_n, bv[i].cs_n);
      if (bv[i].cs_n == 1'b0) check($sformatf("boot_addr_c%0d", bv[i].cyc), eep_addr, bv[i].addr);
      check($sformatf("boot_ld_c%0d", bv[i].cyc), coef_ld, bv[i].ld);
      if (bv[i].ld != 4'd0) check($sformatf("boot_data_c%0d", bv[i].cyc), coef_data, ref_mem[bv[i].idx]);
      check($sformatf("boot_done_c%0d", bv[i].cyc), boot_done, bv[i].bd);
      if (i == 0 && pre_req) begin
        cmd_wr = 1'b0; cmd_addr = 2'd3; cmd_req = 1'b1;
      end
    end
    if (pre_req) begin
      dj = -1;
      for (int c = 10; c <= 20; c++) begin
        @(negedge clk);
        if (cmd_done) begin
          dj = c;
          cmd_req = 1'b0;
          break;
        end
      end
      ref_cmd_rdata = ref_mem[3];
      check("preboot_done_cycle", dj, 11);
      check("preboot_rdata", cmd_rdata, ref_cmd_rdata);
      cmd_req = 1'b0;
      @(negedge clk);
    end
  endtask

  // Called at a negedge while the DUT is in IDLE; returns at a negedge in IDLE
  task automatic run_pair(input bit do_cmd, input bit wr, input logic [1:0] ca, input logic [13:0] wd,
                          input bit do_dp, input logic [1:0] da);
    int cmd_j = -1, dp_j = -1, pmp_n = 0, runs = 0, low_n = 0, exp_c = 0, exp_low = 0;
    logic prev_cs = 1'b1;
    logic [13:0] c_rd = '0, d_rd = '0;
    bit dst_ok = 1'b1;
    cmd_wr = wr; cmd_addr = ca; cmd_wdata = wd; dp_addr = da;
    cmd_req = do_cmd; dp_req = do_dp;
    for (int j = 1; j <= 80; j++) begin
      @(negedge clk);
      if (!eep_cs_n) begin
        low_n++;
        if (prev_cs) runs++;
      end
      prev_cs = eep_cs_n;
      if (chrg_pmp_en) begin
        pmp_n++;
        if (dst !== wd || eep_r_w_n !== 1'b0 || eep_addr !== ca) dst_ok = 1'b0;
      end
      if (cmd_done) begin cmd_j = j; c_rd = cmd_rdata; cmd_req = 1'b0; end
      if (dp_vld)   begin dp_j = j;  d_rd = dp_rdata;  dp_req = 1'b0; end
      if ((!do_cmd || cmd_j > 0) && (!do_dp || dp_j > 0)) break;
    end
    cmd_req = 1'b0; dp_req = 1'b0;
    @(negedge clk);
    if (do_cmd) begin
      exp_c = wr ? CP + 1 : 2;
      if (wr) ref_mem[ca] = wd;
      else    ref_cmd_rdata = ref_mem[ca];
      check(wr ? "wr_latency" : "rd_latency", cmd_j, exp_c);
      check(wr ? "wr_cmd_rdata_kept" : "rd_cmd_rdata", c_rd, ref_cmd_rdata);
      if (wr) begin
        check("wr_pmp_cycles", pmp_n, CP);
        check("wr_pins", dst_ok, 1'b1);
      end
      exp_low = wr ? CP : 1;
    end
    if (do_dp) begin
      check("dp_latency", dp_j, do_cmd ? exp_c + 3 : 2);
      check("dp_rdata", d_rd, ref_mem[da]);
      exp_low = exp_low + 1;
    end
    check("cs_runs", runs, int'(do_cmd) + int'(do_dp));
    check("cs_low_cycles", low_n, exp_low);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mode;
    bv[0] = '{1, 1'b0, 2'd0, 4'b0000, 0, 1'b0};
    bv[1] = '{2, 1'b1, 2'd0, 4'b0001, 0, 1'b0};
    bv[2] = '{3, 1'b0, 2'd1, 4'b0000, 0, 1'b0};
    bv[3] = '{4, 1'b1, 2'd0, 4'b0010, 1, 1'b0};
    bv[4] = '{5, 1'b0, 2'd2, 4'b0000, 0, 1'b0};
    bv[5] = '{6, 1'b1, 2'd0, 4'b0100, 2, 1'b0};
    bv[6] = '{7, 1'b0, 2'd3, 4'b0000, 0, 1'b0};
    bv[7] = '{8, 1'b1, 2'd0, 4'b1000, 3, 1'b0};
    bv[8] = '{9, 1'b1, 2'd0, 4'b0000, 0, 1'b1};

    @(negedge clk);
    reset_boot(1'b0);

    run_pair(1'b1, 1'b0, 2'd2, 14'h0, 1'b0, 2'd0);
    run_pair(1'b1, 1'b1, 2'd1, 14'h2AAA, 1'b0, 2'd0);
    run_pair(1'b1, 1'b0, 2'd1, 14'h0, 1'b0, 2'd0);
    run_pair(1'b1, 1'b0, 2'd0, 14'h0, 1'b1, 2'd3);
    run_pair(1'b0, 1'b0, 2'd0, 14'h0, 1'b1, 2'd1);

    cmd_wr = 1'b1; cmd_addr = 2'd1; cmd_wdata = 14'h1555; cmd_req = 1'b1;
    repeat (10) @(negedge clk);
    check("midwr_pmp_active", chrg_pmp_en, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midwr_pmp_drop", chrg_pmp_en, 1'b0);
    check("midwr_no_done", cmd_done, 1'b0);
    cmd_req = 1'b0;
    reset_boot(1'b0);
    run_pair(1'b1, 1'b0, 2'd1, 14'h0, 1'b0, 2'd0);

    reset_boot(1'b1);

    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 2);
      run_pair(mode != 2, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 14'($urandom),
               mode != 0, 2'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
